// File: rtl/id_ex_stage.sv
// Decode and ID/EX pipeline register with an 8-entry register file written by writeback.
// Define ID_EX_WB_BYPASS_EN so that a same-cycle writeback is forwarded into the operand read.
module id_ex_stage #(
  parameter int DW   = 19,
  parameter int NREG = 8,
  parameter int NOPS = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  input  logic [DW-1:0]           instr,
  output logic                    instr_ready,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    wb_en,
  input  logic [$clog2(NREG)-1:0] wb_addr,
  input  logic [DW-1:0]           wb_data,
  output logic                    ex_valid,
  output logic [NOPS-1:0]         alu_control,
  output logic [DW-1:0]           op_a,
  output logic [DW-1:0]           op_b,
  output logic [$clog2(NREG)-1:0] ex_rd,
  output logic                    ex_reg_write,
  output logic                    ex_illegal
);
  localparam int AW  = $clog2(NREG);
  localparam int OPW = 5;

  typedef struct packed {
    logic [NOPS-1:0] alu;
    logic [AW-1:0]   rd;
    logic            reg_write;
    logic            illegal;
    logic            zero_b;
  } dec_t;

  logic [NREG-1:0][DW-1:0] regs;
  logic [OPW-1:0]          opcode;
  logic [AW-1:0]           rd, rs1, rs2;
  logic [DW-1:0]           rs1_data, rs2_data;
  dec_t                    dec;
  logic                    unused_bits;

  assign opcode      = instr[DW-1 -: OPW];
  assign rd          = instr[DW-OPW-1 -: AW];
  assign rs1         = instr[DW-OPW-AW-1 -: AW];
  assign rs2         = instr[DW-OPW-2*AW-1 -: AW];
  assign unused_bits = ^instr[DW-OPW-3*AW-1:0];
  assign instr_ready = ~stall;

  // Opcode n lights bit NOPS-1-n, so ADD (0) is the MSB.
  always_comb begin
    dec           = '0;
    dec.rd        = rd;
    if (opcode < OPW'(NOPS)) begin
      dec.alu[OPW'(NOPS-1) - opcode] = 1'b1;
      dec.reg_write = (opcode <= 5'd9) || (opcode == 5'd15);
      dec.zero_b    = (opcode == 5'd4) || (opcode == 5'd5) || (opcode == 5'd9);
    end else begin
      dec.illegal = 1'b1;
    end
  end

`ifdef ID_EX_WB_BYPASS_EN
  assign rs1_data = (rs1 == '0) ? '0 : (wb_en && wb_addr == rs1) ? wb_data : regs[rs1];
  assign rs2_data = (rs2 == '0) ? '0 : (wb_en && wb_addr == rs2) ? wb_data : regs[rs2];
`else
  // Old data on a same-cycle read/write; the hazard unit covers the gap.
  assign rs1_data = (rs1 == '0) ? '0 : regs[rs1];
  assign rs2_data = (rs2 == '0) ? '0 : regs[rs2];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else if (wb_en && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      alu_control  <= '0;
      op_a         <= '0;
      op_b         <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (stall) begin
      ex_valid     <= ex_valid;
    end else if (instr_valid) begin
      ex_valid     <= 1'b1;
      alu_control  <= dec.alu;
      op_a         <= rs1_data;
      op_b         <= dec.zero_b ? '0 : rs2_data;
      ex_rd        <= dec.rd;
      ex_reg_write <= dec.reg_write;
      ex_illegal   <= dec.illegal;
    end else begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, operand read, stall/flush, r0 and same-cycle writeback.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst, instr_valid, stall, flush, wb_en;
  logic [18:0] instr, wb_data;
  logic [2:0]  wb_addr;
  logic        instr_ready, ex_valid, ex_reg_write, ex_illegal;
  logic [19:0] alu_control;
  logic [18:0] op_a, op_b;
  logic [2:0]  ex_rd;
  int          passed = 0;
  int          total  = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .stall(stall), .flush(flush), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .ex_valid(ex_valid),
    .alu_control(alu_control), .op_a(op_a), .op_b(op_b), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] mk(input logic [4:0] op, input logic [2:0] d,
                                     input logic [2:0] s1, input logic [2:0] s2);
    return {op, d, s1, s2, 5'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wb(input logic [2:0] a, input logic [18:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; stall = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_valid", ex_valid, 0);
    check("rst_alu", alu_control, 0);
    check("rst_opa", op_a, 0);
    check("rst_opb", op_b, 0);
    check("rst_rd", ex_rd, 0);
    check("rst_rw", ex_reg_write, 0);
    check("rst_ill", ex_illegal, 0);
    check("rst_ready", instr_ready, 1);

    // Every register reads zero after reset.
    instr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      instr = mk(5'd0, 3'd0, 3'(i), 3'(i + 1));
      tick();
      check($sformatf("rst_reg_a%0d", i), op_a, 0);
      check($sformatf("rst_reg_b%0d", i), op_b, 0);
    end
    instr_valid = 1'b0;
    wb(3'd1, 19'h00005);
    check("idle_valid", ex_valid, 0);
    check("idle_rw", ex_reg_write, 0);
    wb(3'd2, 19'h00003);
    wb(3'd4, 19'h00001);

    instr_valid = 1'b1; instr = mk(5'd0, 3'd3, 3'd1, 3'd2);
    tick();
    check("add_alu", alu_control, 20'h80000);
    check("add_opa", op_a, 5);
    check("add_opb", op_b, 3);
    check("add_rd", ex_rd, 3);
    check("add_rw", ex_reg_write, 1);
    check("add_valid", ex_valid, 1);

    instr = mk(5'd4, 3'd3, 3'd1, 3'd2);
    tick();
    check("inc_alu", alu_control, 20'h08000);
    check("inc_opa", op_a, 5);
    check("inc_opb", op_b, 0);
    check("inc_rw", ex_reg_write, 1);

    instr = mk(5'd25, 3'd3, 3'd1, 3'd2);
    tick();
    check("ill_alu", alu_control, 0);
    check("ill_flag", ex_illegal, 1);
    check("ill_rw", ex_reg_write, 0);
    check("ill_valid", ex_valid, 1);

    instr = mk(5'd1, 3'd5, 3'd2, 3'd1);
    tick();
    check("sub_alu", alu_control, 20'h40000);
    check("sub_opa", op_a, 3);
    check("sub_opb", op_b, 5);
    check("sub_ill", ex_illegal, 0);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr = mk(5'd8, 3'(6 + i % 2), 3'd1, 3'd2);
      #1;
      check("stall_ready", instr_ready, 0);
      tick();
      check("stall_alu", alu_control, 20'h40000);
      check("stall_opa", op_a, 3);
      check("stall_rd", ex_rd, 5);
      check("stall_valid", ex_valid, 1);
    end
    stall = 1'b0; instr = mk(5'd8, 3'd6, 3'd1, 3'd2);
    tick();
    check("xor_alu", alu_control, 20'h00800);
    check("xor_opa", op_a, 5);
    check("xor_opb", op_b, 3);
    check("xor_rd", ex_rd, 6);

    stall = 1'b1; flush = 1'b1; instr = mk(5'd0, 3'd7, 3'd1, 3'd2);
    tick();
    check("flush_valid", ex_valid, 0);
    check("flush_rw", ex_reg_write, 0);
    check("flush_hold", alu_control, 20'h00800);
    stall = 1'b0; flush = 1'b0; instr_valid = 1'b0;

    wb(3'd0, 19'h00007);
    instr_valid = 1'b1; instr = mk(5'd0, 3'd1, 3'd0, 3'd0);
    tick();
    check("r0_opa", op_a, 0);
    check("r0_valid", ex_valid, 1);
    instr_valid = 1'b0;
    tick();
    check("bubble_valid", ex_valid, 0);
    check("bubble_hold", alu_control, 20'h80000);

    // Same-cycle writeback to the register being read.
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 19'h7FFFF;
    instr_valid = 1'b1; instr = mk(5'd0, 3'd1, 3'd4, 3'd0);
    tick();
    wb_en = 1'b0;
`ifdef ID_EX_WB_BYPASS_EN
    check("byp_opa", op_a, 19'h7FFFF);
`else
    check("byp_opa", op_a, 19'h00001);
`endif
    tick();
    check("after_wb_opa", op_a, 19'h7FFFF);

    instr = mk(5'd9, 3'd2, 3'd1, 3'd2);
    tick();
    check("not_alu", alu_control, 20'h00400);
    check("not_opb", op_b, 0);
    check("not_rw", ex_reg_write, 1);
    instr = mk(5'd15, 3'd2, 3'd1, 3'd2);
    tick();
    check("ld_alu", alu_control, 20'h00010);
    check("ld_rw", ex_reg_write, 1);
    instr = mk(5'd16, 3'd2, 3'd1, 3'd2);
    tick();
    check("st_alu", alu_control, 20'h00008);
    check("st_rw", ex_reg_write, 0);
    instr = mk(5'd19, 3'd2, 3'd1, 3'd2);
    tick();
    check("fft_alu", alu_control, 20'h00001);
    check("fft_rw", ex_reg_write, 0);

    // Reset beats wb_en and flush, and clears the register file.
    rst = 1'b1; flush = 1'b1; wb_en = 1'b1; wb_addr = 3'd1; wb_data = 19'h00009;
    tick();
    check("rst2_valid", ex_valid, 0);
    check("rst2_alu", alu_control, 0);
    check("rst2_opa", op_a, 0);
    rst = 1'b0; flush = 1'b0; wb_en = 1'b0;
    instr = mk(5'd0, 3'd3, 3'd1, 3'd2);
    tick();
    check("rst2_r1", op_a, 0);
    check("rst2_r2", op_b, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
